// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receive definitions.
// Holds FSM state encodings and default frame geometry.
package uart_rx_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input.
// RST_VAL sets the level both flops take during reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the raw input one stage per clock
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // synchroniser flops, preset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with valid/ready output.
// Optional parity checking is enabled by UART_RX_PARITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_HALF =
    TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: illegal parameter set");
  end

  logic rxd_s;

  uart_state_e state_q, state_d;

  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // frame FSM: advances only on oversample ticks
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`else
    par_bad_d   = 1'b0;
`endif
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    if (rx_clk) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_HALF) begin
            if (rxd_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_bad_d = rxd_s ^ (^shift_q) ^
                        (PARITY_ODD != 0);
            state_d   = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
`else
          state_d = ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxd_s) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // output handshake: deliver or drop the completed byte
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_ready) begin
        valid_d      = 1'b1;
        data_d       = shift_q;
        parity_err_d = par_bad_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // receive-side state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      done_q    <= done_d;
    end
  end

  // output registers and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != ST_IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx.
// rx_clk runs at clk/4, so one bit is 64 clk.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_clk;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  int n_pe_co = 0;
  int n_busy = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       bad_par;
    int         exp_nv;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t vecs[$];

  uart_rx u_dut (
    .clk         (clk),
    .rst         (rst),
    .rx_clk      (rx_clk),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    rx_clk = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      rx_clk = 1'b1;
      @(negedge clk);
      rx_clk = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      n_valid = n_valid + 1;
      last_data = rx_data;
      if (parity_err) n_pe_co = n_pe_co + 1;
    end
    if (rx_busy && !prev_busy) n_busy = n_busy + 1;
    if (frame_err) n_fe = n_fe + 1;
    if (overrun_err) n_ov = n_ov + 1;
    if (parity_err) n_pe = n_pe + 1;
    prev_valid = rx_valid;
    prev_busy = rx_busy;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    wait_bits(n);
  endtask

  // leaves rxd at the stop level on return
  task automatic send_frame(input logic [7:0] d,
                            input logic stop_b,
                            input logic bad_par);
    rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ bad_par;
    wait_bits(1);
`endif
    rxd = stop_b;
    wait_bits(1);
  endtask

  int b_nv, b_fe, b_ov, b_pe, b_pc, b_bz;

  task automatic snap();
    b_nv = n_valid;
    b_fe = n_fe;
    b_ov = n_ov;
    b_pe = n_pe;
    b_pc = n_pe_co;
    b_bz = n_busy;
  endtask

  initial begin
    vecs.push_back('{8'h55, 1'b1, 1'b0, 1, 8'h55, 0, 0});
    vecs.push_back('{8'hA3, 1'b1, 1'b0, 1, 8'hA3, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1, 8'h07, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 8'h07, 0, 1});
`endif

    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {19'd0, rx_valid, rx_busy, frame_err,
           overrun_err, parity_err, rx_data},
          32'd0);
    rst = 1'b0;
    idle_bits(1);

    for (int v = 0; v < vecs.size(); v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].stop_b,
                 vecs[v].bad_par);
      idle_bits(2);
      check($sformatf("vec%0d_nvalid", v),
            n_valid - b_nv, vecs[v].exp_nv);
      if (vecs[v].exp_nv > 0)
        check($sformatf("vec%0d_data", v),
              last_data, vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v),
            n_fe - b_fe, vecs[v].exp_fe);
      check($sformatf("vec%0d_ovr", v),
            n_ov - b_ov, 0);
      check($sformatf("vec%0d_perr", v),
            n_pe - b_pe, vecs[v].exp_pe);
      check($sformatf("vec%0d_perr_co", v),
            n_pe_co - b_pc, vecs[v].exp_pe);
      check($sformatf("vec%0d_valid_low", v),
            rx_valid, 0);
    end

    // short low glitch on an idle line
    snap();
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(2);
    check("glitch_busy_rise", n_busy - b_bz, 1);
    check("glitch_busy_now", rx_busy, 0);
    check("glitch_nvalid", n_valid - b_nv, 0);
    check("glitch_flags",
          (n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe),
          0);

    // bad stop bit followed by a held-low line
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_bits(2);
    check("brk_ferr", n_fe - b_fe, 1);
    check("brk_nvalid", n_valid - b_nv, 0);
    check("brk_busy_held", rx_busy, 1);
    idle_bits(1);
    check("brk_busy_rel", rx_busy, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    check("brk_next_nv", n_valid - b_nv, 1);
    check("brk_next_data", last_data, 8'h81);
    check("brk_next_ferr", n_fe - b_fe, 1);

    // overrun with downstream stalled
    snap();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle_bits(1);
    send_frame(8'h22, 1'b1, 1'b0);
    idle_bits(2);
    check("ovr_nvalid", n_valid - b_nv, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_pulse", n_ov - b_ov, 1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_valid_clr", rx_valid, 0);
    check("ovr_no_new", n_valid - b_nv, 1);

    // reset in the middle of the data bits
    snap();
    rxd = 1'b0;
    wait_bits(4);
    check("mid_busy", rx_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_outs",
          {19'd0, rx_valid, rx_busy, frame_err,
           overrun_err, parity_err, rx_data},
          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    check("mid_no_valid", n_valid - b_nv, 0);
    check("mid_no_ferr", n_fe - b_fe, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(2);
    check("mid_next_nv", n_valid - b_nv, 1);
    check("mid_next_data", last_data, 8'h0F);
    check("mid_next_flags",
          (n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe),
          0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
